// File: rtl/seq_det_pkg.sv
// Shared types and default widths for the windowed "101" detector controller.
package seq_det_pkg;

  localparam int unsigned WIN_W_DEF = 8;
  localparam int unsigned CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ctrl_state_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GOT1  = 2'd1,
    S_GOT10 = 2'd2
  } det_state_e;

endpackage

// File: rtl/seq_det_ctrl_if.sv
// Control/status bundle between the bit source, the window controller and status logic.
interface seq_det_ctrl_if #(
  parameter int unsigned WIN_W = seq_det_pkg::WIN_W_DEF,
  parameter int unsigned CNT_W = seq_det_pkg::CNT_W_DEF
);

  logic             start;
  logic             abort;
  logic [WIN_W-1:0] win_len;
  logic [CNT_W-1:0] thresh;
  logic             data_bit;
  logic             bit_vld;
  logic             busy;
  logic             det_en_c;
  logic [CNT_W-1:0] match_cnt;
  logic             hit;
  logic             done;

  modport master (
    output start, abort, win_len, thresh, data_bit, bit_vld,
    input  busy, det_en_c, match_cnt, hit, done
  );

  modport slave (
    input  start, abort, win_len, thresh, data_bit, bit_vld,
    output busy, det_en_c, match_cnt, hit, done
  );

endinterface

// File: rtl/seq_det_core.sv
// Overlapping Mealy "101" detector with enable and synchronous clear.
module seq_det_core
  import seq_det_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic data_bit,
  output logic match_c
);

  det_state_e state;

  assign match_c = en && (state == S_GOT10) && data_bit;

  // A completed match leaves the trailing 1 as the start of the next pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else if (clr) begin
      state <= S_IDLE;
    end else if (en) begin
      unique case (state)
        S_IDLE:  state <= data_bit ? S_GOT1 : S_IDLE;
        S_GOT1:  state <= data_bit ? S_GOT1 : S_GOT10;
        S_GOT10: state <= data_bit ? S_GOT1 : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// Window controller: counts "101" matches over a programmed number of accepted bits.
// Optional SEQ_DET_CTRL_EARLY_STOP_EN ends the window as soon as the threshold is met.
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned WIN_W = WIN_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_det_ctrl_if.slave bus
);

  ctrl_state_e      state;
  logic [WIN_W-1:0] bit_cnt;
  logic [CNT_W-1:0] thr_q;
  logic [CNT_W-1:0] cnt_nxt_c;
  logic             match_c;
  logic             core_clr_c;
  logic             last_c;
  logic             stop_c;

  assign bus.det_en_c = (state == ST_RUN) && bus.bit_vld;
  assign core_clr_c   = ((state == ST_IDLE) && bus.start) ||
                        ((state == ST_RUN) && bus.abort);

  seq_det_core u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (bus.det_en_c),
    .clr      (core_clr_c),
    .data_bit (bus.data_bit),
    .match_c  (match_c)
  );

  // Saturating increment; the counter never wraps back to zero.
  assign cnt_nxt_c = (match_c && (bus.match_cnt != '1)) ? bus.match_cnt + CNT_W'(1)
                                                        : bus.match_cnt;
  assign last_c    = (bit_cnt == WIN_W'(1));

`ifdef SEQ_DET_CTRL_EARLY_STOP_EN
  assign stop_c = (thr_q != '0) && (cnt_nxt_c >= thr_q);
`else
  assign stop_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      bit_cnt       <= '0;
      thr_q         <= '0;
      bus.busy      <= 1'b0;
      bus.match_cnt <= '0;
      bus.hit       <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.start) begin
            if (bus.win_len == '0) begin
              state         <= ST_DONE;
              thr_q         <= bus.thresh;
              bus.match_cnt <= '0;
              bus.hit       <= (bus.thresh == '0);
              bus.done      <= 1'b1;
            end else if (!bus.abort) begin
              state         <= ST_RUN;
              bit_cnt       <= bus.win_len;
              thr_q         <= bus.thresh;
              bus.busy      <= 1'b1;
              bus.match_cnt <= '0;
              bus.hit       <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            state    <= ST_IDLE;
            bus.busy <= 1'b0;
            bus.hit  <= 1'b0;
          end else if (bus.bit_vld) begin
            bus.match_cnt <= cnt_nxt_c;
            bit_cnt       <= bit_cnt - WIN_W'(1);
            // Hit is resolved on the final accepted bit so it is valid alongside done.
            if (last_c || stop_c) begin
              state    <= ST_DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              bus.hit  <= stop_c || (cnt_nxt_c >= thr_q);
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Randomized self-checking bench; two instances (CNT_W=4 and CNT_W=2) share one stimulus stream.
module tb_seq_det_ctrl;

  localparam int unsigned WA = 8;
  localparam int unsigned CA = 4;
  localparam int unsigned CB = 2;
`ifdef SEQ_DET_CTRL_EARLY_STOP_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start, abort, data_bit, bit_vld;
  logic [7:0] win_len;
  logic [3:0] thresh;
  int         checks = 0;
  int         errors = 0;
  int         bits[$];

  seq_det_ctrl_if #(.WIN_W(WA), .CNT_W(CA)) ifa ();
  seq_det_ctrl_if #(.WIN_W(WA), .CNT_W(CB)) ifb ();

  assign ifa.start = start;    assign ifb.start = start;
  assign ifa.abort = abort;    assign ifb.abort = abort;
  assign ifa.win_len = win_len; assign ifb.win_len = win_len;
  assign ifa.thresh = thresh;  assign ifb.thresh = thresh[1:0];
  assign ifa.data_bit = data_bit; assign ifb.data_bit = data_bit;
  assign ifa.bit_vld = bit_vld; assign ifb.bit_vld = bit_vld;

  seq_det_ctrl #(.WIN_W(WA), .CNT_W(CA)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  seq_det_ctrl #(.WIN_W(WA), .CNT_W(CB)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts 1-0-1 occurrences in the first n entries of bits with overlap and saturation.
  function automatic void model(input int n, input int cmax, input int thr, input bit early,
                                output int cnt, output int cons, output bit hit);
    cnt = 0; cons = n; hit = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i >= 2 && bits[i-2] == 1 && bits[i-1] == 0 && bits[i] == 1 && cnt < cmax) cnt++;
      if (early && thr != 0 && cnt >= thr) begin
        cons = i + 1; hit = 1'b1; return;
      end
    end
    hit = (cnt >= thr);
  endfunction

  task automatic run_window(input string name, input int len, input int thr, input int gap_pct);
    int ca, na, cb, nb, pa, pb, tmp, nmax, g;
    bit ha, hb, th;
    model(len, 15, thr, EARLY, ca, na, ha);
    model(len, 3, thr & 3, EARLY, cb, nb, hb);
    start = 1'b1; win_len = 8'(len); thresh = 4'(thr);
    tick();
    start = 1'b0;
    checks++; if (ifa.busy !== (len != 0) || ifa.done !== (len == 0) || ifa.match_cnt !== 4'd0 ||
                  ifa.hit !== ((len == 0) ? ha : 1'b0)) begin
      errors++; $display("FAIL %s a.start busy=%b done=%b cnt=%0d hit=%b exp_hit=%b", name,
                         ifa.busy, ifa.done, ifa.match_cnt, ifa.hit, ha);
    end
    checks++; if (ifb.busy !== (len != 0) || ifb.done !== (len == 0) || ifb.match_cnt !== 2'd0 ||
                  ifb.hit !== ((len == 0) ? hb : 1'b0)) begin
      errors++; $display("FAIL %s b.start busy=%b done=%b cnt=%0d hit=%b exp_hit=%b", name,
                         ifb.busy, ifb.done, ifb.match_cnt, ifb.hit, hb);
    end
    nmax = (na > nb) ? na : nb;
    for (int k = 1; k <= nmax; k++) begin
      g = 0;
      while (g < 3 && $urandom_range(99) < gap_pct) begin
        bit_vld = 1'b0; data_bit = 1'($urandom);
        #1;
        checks++; if (ifa.det_en_c !== 1'b0 || ifb.det_en_c !== 1'b0) begin
          errors++; $display("FAIL %s gap det_en a=%b b=%b exp 0", name, ifa.det_en_c, ifb.det_en_c);
        end
        tick();
        checks++; if (ifa.done !== 1'b0 || ifb.done !== 1'b0) begin
          errors++; $display("FAIL %s gap done a=%b b=%b exp 0", name, ifa.done, ifb.done);
        end
        g++;
      end
      bit_vld = 1'b1; data_bit = 1'(bits[k-1]);
      #1;
      checks++; if (ifa.det_en_c !== (k <= na) || ifb.det_en_c !== (k <= nb)) begin
        errors++; $display("FAIL %s det_en k=%0d a=%b b=%b exp %b %b", name, k,
                           ifa.det_en_c, ifb.det_en_c, (k <= na), (k <= nb));
      end
      tick();
      bit_vld = 1'b0;
      model(k, 15, thr, 1'b0, pa, tmp, th);
      model(k, 3, thr & 3, 1'b0, pb, tmp, th);
      checks++; if (ifa.busy !== (k < na) || ifa.done !== (k == na) ||
                    ifa.match_cnt !== 4'((k <= na) ? pa : ca) || ifa.hit !== ((k >= na) ? ha : 1'b0)) begin
        errors++; $display("FAIL %s a k=%0d busy=%b done=%b cnt=%0d hit=%b exp %b %b %0d %b", name, k,
                           ifa.busy, ifa.done, ifa.match_cnt, ifa.hit, (k < na), (k == na),
                           (k <= na) ? pa : ca, (k >= na) ? ha : 1'b0);
      end
      checks++; if (ifb.busy !== (k < nb) || ifb.done !== (k == nb) ||
                    ifb.match_cnt !== 2'((k <= nb) ? pb : cb) || ifb.hit !== ((k >= nb) ? hb : 1'b0)) begin
        errors++; $display("FAIL %s b k=%0d busy=%b done=%b cnt=%0d hit=%b exp %b %b %0d %b", name, k,
                           ifb.busy, ifb.done, ifb.match_cnt, ifb.hit, (k < nb), (k == nb),
                           (k <= nb) ? pb : cb, (k >= nb) ? hb : 1'b0);
      end
    end
    tick();
    checks++; if (ifa.done !== 1'b0 || ifa.busy !== 1'b0 || ifa.match_cnt !== 4'(ca) || ifa.hit !== ha) begin
      errors++; $display("FAIL %s a.hold done=%b busy=%b cnt=%0d hit=%b exp 0 0 %0d %b", name,
                         ifa.done, ifa.busy, ifa.match_cnt, ifa.hit, ca, ha);
    end
    checks++; if (ifb.done !== 1'b0 || ifb.busy !== 1'b0 || ifb.match_cnt !== 2'(cb) || ifb.hit !== hb) begin
      errors++; $display("FAIL %s b.hold done=%b busy=%b cnt=%0d hit=%b exp 0 0 %0d %b", name,
                         ifb.done, ifb.busy, ifb.match_cnt, ifb.hit, cb, hb);
    end
  endtask

  task automatic test_reset();
    start = 1'b0; abort = 1'b0; data_bit = 1'b0; bit_vld = 1'b0; win_len = '0; thresh = '0;
    rst_n = 1'b0;
    repeat (2) tick();
    checks++; if (ifa.busy !== 1'b0 || ifa.done !== 1'b0 || ifa.hit !== 1'b0 ||
                  ifa.match_cnt !== 4'd0 || ifa.det_en_c !== 1'b0) begin
      errors++; $display("FAIL reset_state busy=%b done=%b hit=%b cnt=%0d exp all 0",
                         ifa.busy, ifa.done, ifa.hit, ifa.match_cnt);
    end
    rst_n = 1'b1;
    tick();
    // Reset in the middle of a window after one match has been counted.
    start = 1'b1; win_len = 8'd8; thresh = 4'd1;
    tick();
    start = 1'b0; bit_vld = 1'b1;
    foreach (bits[i]) bits.delete(i);
    bits = '{1, 0, 1};
    for (int i = 0; i < 3; i++) begin data_bit = 1'(bits[i]); tick(); end
    checks++; if (ifa.match_cnt !== 4'd1 || ifa.busy !== 1'b1) begin
      errors++; $display("FAIL pre_reset cnt=%0d busy=%b exp 1 1", ifa.match_cnt, ifa.busy);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (ifa.busy !== 1'b0 || ifa.det_en_c !== 1'b0 || ifa.match_cnt !== 4'd0 ||
                  ifb.busy !== 1'b0 || ifb.det_en_c !== 1'b0 || ifb.match_cnt !== 2'd0) begin
      errors++; $display("FAIL mid_reset a busy=%b en=%b cnt=%0d b busy=%b en=%b cnt=%0d exp 0",
                         ifa.busy, ifa.det_en_c, ifa.match_cnt, ifb.busy, ifb.det_en_c, ifb.match_cnt);
    end
    tick();
    rst_n = 1'b1; bit_vld = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bits = '{1, 0, 1, 0, 1};
    run_window("basic", 5, 2, 0);
  endtask

  task automatic test_gaps();
    bits = '{1, 1, 0, 0};
    run_window("gaps", 4, 1, 70);
  endtask

  task automatic test_zero_len();
    bits = '{};
    run_window("zero_len", 0, 0, 0);
    bits = '{1, 0, 1};
    run_window("after_zero", 3, 1, 0);
  endtask

  task automatic test_abort();
    int seq[5];
    // Short abort with an ignored start inside the window.
    start = 1'b1; win_len = 8'd8; thresh = 4'd1;
    tick();
    start = 1'b1; win_len = 8'd1; bit_vld = 1'b1; data_bit = 1'b1;
    tick();
    start = 1'b0; data_bit = 1'b0;
    tick();
    bit_vld = 1'b0;
    checks++; if (ifa.busy !== 1'b1 || ifa.done !== 1'b0) begin
      errors++; $display("FAIL abort_prerun busy=%b done=%b exp 1 0", ifa.busy, ifa.done);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (ifa.busy !== 1'b0 || ifa.done !== 1'b0 || ifa.hit !== 1'b0 || ifa.match_cnt !== 4'd0) begin
      errors++; $display("FAIL abort_short busy=%b done=%b hit=%b cnt=%0d exp 0 0 0 0",
                         ifa.busy, ifa.done, ifa.hit, ifa.match_cnt);
    end
    // Longer abort with a nonzero frozen count.
    seq = '{1, 0, 1, 0, 1};
    start = 1'b1; win_len = 8'd8; thresh = 4'd7;
    tick();
    start = 1'b0; bit_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin data_bit = 1'(seq[i]); tick(); end
    bit_vld = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++; if (ifa.done !== 1'b0 || ifa.busy !== 1'b0 || ifa.hit !== 1'b0 || ifa.match_cnt !== 4'd2 ||
                    ifb.done !== 1'b0 || ifb.match_cnt !== 2'd2) begin
        errors++; $display("FAIL abort_freeze i=%0d a done=%b busy=%b hit=%b cnt=%0d b done=%b cnt=%0d exp 0 0 0 2 0 2",
                           i, ifa.done, ifa.busy, ifa.hit, ifa.match_cnt, ifb.done, ifb.match_cnt);
      end
      tick();
    end
    // The next window must not inherit detector progress.
    bits = '{0, 1, 1, 1};
    run_window("after_abort", 4, 1, 0);
  endtask

  task automatic test_saturate();
    bits = '{};
    for (int i = 0; i < 20; i++) bits.push_back((i % 2 == 0) ? 1 : 0);
    run_window("saturate", 20, 2, 0);
  endtask

  task automatic test_random();
    int len, thr;
    for (int w = 0; w < 25; w++) begin
      len = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(24, 1));
      thr = int'($urandom_range(6));
      bits = '{};
      for (int i = 0; i < len; i++) bits.push_back(($urandom_range(99) < 60) ? 1 : 0);
      run_window("random", len, thr, 30);
    end
  endtask

  task automatic test_back_to_back();
    bits = '{1, 0, 1, 1, 0, 1};
    run_window("b2b_first", 6, 3, 0);
    bits = '{0, 1, 0, 1, 0, 1};
    run_window("b2b_second", 6, 2, 20);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_zero_len();
    test_abort();
    test_saturate();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
